// File: rtl/store_buffer.sv
// Store buffer between the pipeline MEM stage and a single-port memory system.
// Stores are queued in a small FIFO and drained in the background. Loads are
// answered from the youngest matching buffered store, or else from memory.
module store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [5:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ready,
    output logic       cpu_rvalid,
    output logic [7:0] cpu_rdata,
    output logic [5:0] mem_address,
    output logic [7:0] mem_writedata,
    output logic       mem_writeen,
    input  logic       mem_hit,
    input  logic [7:0] mem_readdata
);

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 8;
    // DEPTH is a power of two and at least 2, so pointers wrap naturally.
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sb_entry_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    sb_entry_t       r_fifo [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_pend;
    logic [AW-1:0]   r_pend_addr;
    logic            r_rvalid;
    logic [DW-1:0]   r_rdata;

    logic            w_accept;
    logic            w_enq;
    logic            w_deq;
    logic            w_rd_done;
    logic            w_fwd_hit;
    logic [DW-1:0]   w_fwd_data;
    logic [PW-1:0]   w_idx;

    // Accept only with space left and no load waiting on memory.
    assign cpu_ready  = (r_count < CW'(DEPTH)) && !r_pend;
    assign w_accept   = cpu_req && cpu_ready;
    assign w_enq      = w_accept && cpu_we;
    assign w_deq      = (r_state == S_WR) && mem_hit;
    assign w_rd_done  = (r_state == S_RD) && mem_hit;
    assign cpu_rvalid = r_rvalid;
    assign cpu_rdata  = r_rdata;

    // Youngest-match search: walk oldest to youngest, the last hit wins.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + PW'(i);
            if ((CW'(i) < r_count) && (r_fifo[w_idx].addr == cpu_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_fifo[w_idx].data;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and memory-side drive; pending loads win only from IDLE.
    always_comb begin
        w_state_nxt   = r_state;
        mem_address   = '0;
        mem_writedata = '0;
        mem_writeen   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend) begin
                    w_state_nxt = S_RD;
                end else if (r_count != '0) begin
                    w_state_nxt = S_WR;
                end
            end
            S_WR: begin
                mem_address   = r_fifo[r_rd_ptr].addr;
                mem_writedata = r_fifo[r_rd_ptr].data;
                mem_writeen   = 1'b1;
                if (mem_hit) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD: begin
                mem_address = r_pend_addr;
                if (mem_hit) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FIFO storage; entries are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo[r_wr_ptr] <= '{addr: cpu_addr, data: cpu_wdata};
        end
    end

    // FIFO pointers and occupancy; enqueue and dequeue may share an edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Load handling: forward from the buffer or park the load for memory.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_rvalid <= 1'b0;
            if (w_accept && !cpu_we) begin
                if (w_fwd_hit) begin
                    r_rvalid <= 1'b1;
                    r_rdata  <= w_fwd_data;
                end else begin
                    r_pend      <= 1'b1;
                    r_pend_addr <= cpu_addr;
                end
            end
            if (w_rd_done) begin
                r_pend   <= 1'b0;
                r_rvalid <= 1'b1;
                r_rdata  <= mem_readdata;
            end
        end
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low; sampled on the rising edge of clk.
REQ-003 SHALL have port: cpu_req  input  1  request valid from pipeline MEM stage.
REQ-004 SHALL have port: cpu_we  input  1  1 = store, 0 = load.
REQ-005 SHALL have port: cpu_addr  input  6  byte address.
REQ-006 SHALL have port: cpu_wdata  input  8  store data.
REQ-007 SHALL have port: cpu_ready  output  1  request accepted at this edge when cpu_req=1.
REQ-008 SHALL have port: cpu_rvalid  output  1  load data valid, one-cycle pulse.
REQ-009 SHALL have port: cpu_rdata  output  8  load data, held until next rvalid.
REQ-010 SHALL have port: mem_address  output  6  to memory system address.
REQ-011 SHALL have port: mem_writedata  output  8  to memory system writedata.
REQ-012 SHALL have port: mem_writeen  output  1  to memory system writeen.
REQ-013 SHALL have port: mem_hit  input  1  memory system hit; access completes at an edge where mem_hit=1.
REQ-014 SHALL have port: mem_readdata  input  8  memory system readdata.
REQ-015 SHALL have parameter: DEPTH, default 4, store-buffer entries (power of two).

Function
REQ-016 SHALL hold stores in a DEPTH-entry FIFO {addr, data}; count 0..DEPTH; pointers wrap modulo DEPTH.
REQ-017 SHALL drive cpu_ready = (count<DEPTH) and no load pending/in flight; combinational from registered state.
REQ-018 SHALL enqueue an accepted store at the edge; cpu_rvalid not asserted for stores.
REQ-019 SHALL, for an accepted load, compare cpu_addr against all valid entries; on match, return the youngest matching data with cpu_rvalid=1 in the next cycle and make no memory access.
REQ-020 SHALL, on an accepted load with no match, latch it as pending and serve it through memory.
REQ-021 SHALL implement FSM IDLE/WR/RD: IDLE -> RD if load pending; else IDLE -> WR if count>0; else stay.
REQ-022 SHALL, in WR, drive mem_address/mem_writedata = head entry, mem_writeen=1; on mem_hit=1, dequeue head and go IDLE.
REQ-023 SHALL, in RD, drive mem_address = pending addr, mem_writeen=0; on mem_hit=1, capture mem_readdata into cpu_rdata, pulse cpu_rvalid next cycle, clear pending, go IDLE.
REQ-024 SHALL give a pending load priority over draining only at IDLE; a WR in progress is never aborted.
REQ-025 SHALL drive mem_address=0, mem_writedata=0, mem_writeen=0 in IDLE.
REQ-026 SHALL handle simultaneous enqueue and dequeue at one edge with count unchanged and both pointers advanced.
REQ-027 SHALL, when full, hold cpu_ready=0 until a WR completes; no entry is overwritten.
REQ-028 SHALL wait indefinitely in WR/RD while mem_hit=0 (miss), holding mem outputs stable.

Reset
REQ-029 SHALL, when reset=0 at an edge: count=0, pointers=0, pending cleared, FSM=IDLE, cpu_rvalid=0, cpu_rdata=0, mem outputs 0.
REQ-030 SHALL, on reset mid-WR/RD, discard the access and all buffered stores; cpu_ready=1 in the first cycle after reset deasserts.

Verification
REQ-031 SHALL cover: store 0x05<-0xA1, mem_hit=1 -> one WR cycle with mem_address=0x05, mem_writedata=0xA1, then count=0.
REQ-032 SHALL cover: stores 0x10<-0x11 then 0x10<-0x22 held (mem_hit=0), load 0x10 -> cpu_rvalid next cycle, cpu_rdata=0x22, no RD state.
REQ-033 SHALL cover: 4 stores with mem_hit=0 -> cpu_ready=0; fifth cpu_req held; mem_hit=1 one cycle -> head dequeued, cpu_ready=1, fifth store accepted.
REQ-034 SHALL cover: load 0x3F, no match, mem_hit=0 for 3 cycles then 1 with mem_readdata=0x5C -> cpu_rvalid one cycle later, cpu_rdata=0x5C.
REQ-035 SHALL cover: reset=0 during WR with count=3 -> count=0, mem_writeen=0, FSM=IDLE next cycle.
